// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator processor: PC source encodings,
// opcode space and instruction field widths.
package accum_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned IMM_W    = 10;
  localparam int unsigned WORD_W   = 16;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_JUMP   = 2'd1,
    PCSRC_ALUOUT = 2'd2,
    PCSRC_ACC    = 2'd3
  } pcsrc_e;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ILLEGAL = 6'h00,
    OP_LDA  = 6'h01, OP_STA  = 6'h02, OP_LDI  = 6'h03, OP_ADD  = 6'h04,
    OP_SUB  = 6'h05, OP_AND  = 6'h06, OP_OR   = 6'h07, OP_JMP  = 6'h08,
    OP_JMPI = 6'h09, OP_BEQ  = 6'h0A, OP_BNE  = 6'h0B, OP_XOR  = 6'h0C,
    OP_NOT  = 6'h0D, OP_SHL  = 6'h0E, OP_SHR  = 6'h0F, OP_ADDI = 6'h10,
    OP_SUBI = 6'h11, OP_IN   = 6'h12, OP_OUT  = 6'h13
  } opcode_e;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op,
                                       input logic [OPCODE_W-1:0] max_op);
    return (op != '0) && (op <= max_op);
  endfunction

endpackage

// File: rtl/pc_ir_perf_cnt.sv
// Saturating instruction and taken-branch counters for pc_ir_unit.
module pc_ir_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_inc,
  input  logic        taken_inc,
  output logic [31:0] instr_count,
  output logic [15:0] taken_count
);

  logic [31:0] instr_q, instr_d;
  logic [15:0] taken_q, taken_d;

  always_comb begin
    instr_d = instr_q;
    taken_d = taken_q;
    if (instr_inc && (instr_q != '1)) instr_d = instr_q + 32'd1;
    if (taken_inc && (taken_q != '1)) taken_d = taken_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      taken_q <= '0;
    end else begin
      instr_q <= instr_d;
      taken_q <= taken_d;
    end
  end

  assign instr_count = instr_q;
  assign taken_count = taken_q;

endmodule

// File: rtl/pc_ir_unit.sv
// PC, IR and branch-resolution stage of the accumulator processor.
// Define PC_IR_PERF_EN to add saturating InstrCount/BranchTakenCount outputs.
module pc_ir_unit
  import accum_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [5:0]  MAX_OPCODE = 6'h13
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  PCWrite,
  input  logic [1:0]  Branch,
  input  logic [1:0]  BneOrBeq,
  input  logic        IRWrite,
  input  logic [15:0] MemRdata,
  input  logic [15:0] ALUResult,
  input  logic        Zero,
  input  logic [15:0] AccIn,
  output logic [15:0] PC,
  output logic [15:0] IR,
  output logic [5:0]  Opcode,
  output logic [15:0] ImmSext,
  output logic [15:0] ImmZext,
  output logic [15:0] ALUOut,
  output logic        BranchTaken,
  output logic        IllegalOp
`ifdef PC_IR_PERF_EN
  ,
  output logic [31:0] InstrCount,
  output logic [15:0] BranchTakenCount
`endif
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] alu_out_q, alu_out_d;
  logic        illegal_q, illegal_d;
  logic        taken;
  logic [15:0] pc_sel;
  logic        unused_strobe_bits;

  assign unused_strobe_bits = ^{PCWrite[1], Branch[1], BneOrBeq[1]};

  always_comb begin
    taken  = Branch[0] & (BneOrBeq[0] ? Zero : ~Zero);
    pc_sel = ALUResult;
    unique case (pcsrc_e'(PCSrc))
      PCSRC_ALU:    pc_sel = ALUResult;
      PCSRC_JUMP:   pc_sel = {pc_q[15:11], ir_q[IMM_W-1:0], 1'b0};
      PCSRC_ALUOUT: pc_sel = alu_out_q;
      PCSRC_ACC:    pc_sel = AccIn;
      default:      pc_sel = ALUResult;
    endcase

    // An explicit PC write outranks a branch resolving in the same cycle.
    pc_d = pc_q;
    if (PCWrite[0])  pc_d = {pc_sel[15:1], 1'b0};
    else if (taken)  pc_d = {alu_out_q[15:1], 1'b0};

    ir_d      = IRWrite ? MemRdata : ir_q;
    alu_out_d = ALUResult;
    illegal_d = illegal_q |
                (IRWrite & ~is_legal_op(MemRdata[15:10], MAX_OPCODE));
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      alu_out_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_out_q <= alu_out_d;
      illegal_q <= illegal_d;
    end
  end

  assign PC          = pc_q;
  assign IR          = ir_q;
  assign Opcode      = ir_q[WORD_W-1 -: OPCODE_W];
  assign ImmSext     = {{(WORD_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign ImmZext     = {{(WORD_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  assign ALUOut      = alu_out_q;
  assign BranchTaken = taken;
  assign IllegalOp   = illegal_q;

`ifdef PC_IR_PERF_EN
  pc_ir_perf_cnt u_perf (
    .clk         (CLK),
    .rst_n       (Reset),
    .instr_inc   (IRWrite),
    .taken_inc   (taken),
    .instr_count (InstrCount),
    .taken_count (BranchTakenCount)
  );
`endif

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed, table-driven bench for pc_ir_unit (RESET_PC overridden to 0x0040).
module tb_pc_ir_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [1:0]  PCSrc, PCWrite, Branch, BneOrBeq;
  logic        IRWrite;
  logic [15:0] MemRdata, ALUResult, AccIn;
  logic        Zero;
  logic [15:0] PC, IR, ImmSext, ImmZext, ALUOut;
  logic [5:0]  Opcode;
  logic        BranchTaken, IllegalOp;
`ifdef PC_IR_PERF_EN
  logic [31:0] InstrCount;
  logic [15:0] BranchTakenCount;
`endif

  int checks = 0;
  int errors = 0;

  pc_ir_unit #(.RESET_PC(16'h0040), .MAX_OPCODE(6'h13)) dut (
    .CLK(CLK), .Reset(Reset), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .Branch(Branch), .BneOrBeq(BneOrBeq), .IRWrite(IRWrite),
    .MemRdata(MemRdata), .ALUResult(ALUResult), .Zero(Zero), .AccIn(AccIn),
    .PC(PC), .IR(IR), .Opcode(Opcode), .ImmSext(ImmSext), .ImmZext(ImmZext),
    .ALUOut(ALUOut), .BranchTaken(BranchTaken), .IllegalOp(IllegalOp)
`ifdef PC_IR_PERF_EN
    , .InstrCount(InstrCount), .BranchTakenCount(BranchTakenCount)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  pcw, src, br, bnb;
    logic        irw;
    logic [15:0] mem, alu;
    logic        zero;
    logic [15:0] acc;
    logic [15:0] e_pc, e_ir, e_aluout;
    logic        e_ill, e_taken;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    PCWrite = v.pcw; PCSrc = v.src; Branch = v.br; BneOrBeq = v.bnb;
    IRWrite = v.irw; MemRdata = v.mem; ALUResult = v.alu; Zero = v.zero;
    AccIn = v.acc;
  endtask

  task automatic idle();
    PCWrite = '0; PCSrc = '0; Branch = '0; BneOrBeq = '0; IRWrite = 1'b0;
    MemRdata = '0; ALUResult = '0; Zero = 1'b0; AccIn = '0;
  endtask

  task automatic apply(input int idx, input vec_t v);
    logic [15:0] eir;
    @(negedge CLK);
    drive(v);
    #1 chk($sformatf("v%0d taken", idx), {31'd0, BranchTaken}, {31'd0, v.e_taken});
    @(posedge CLK);
    #1;
    eir = v.e_ir;
    chk($sformatf("v%0d PC", idx), {16'd0, PC}, {16'd0, v.e_pc});
    chk($sformatf("v%0d IR", idx), {16'd0, IR}, {16'd0, eir});
    chk($sformatf("v%0d ALUOut", idx), {16'd0, ALUOut}, {16'd0, v.e_aluout});
    chk($sformatf("v%0d IllegalOp", idx), {31'd0, IllegalOp}, {31'd0, v.e_ill});
    chk($sformatf("v%0d Opcode", idx), {26'd0, Opcode}, {26'd0, eir[15:10]});
    chk($sformatf("v%0d ImmSext", idx), {16'd0, ImmSext}, {16'd0, {{6{eir[9]}}, eir[9:0]}});
    chk($sformatf("v%0d ImmZext", idx), {16'd0, ImmZext}, {16'd0, {6'd0, eir[9:0]}});
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle();
    Reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    idle();
    Reset = 1'b0;
    //               pcw   src   br    bnb   irw   mem       alu       z     acc       e_pc      e_ir      e_aluout  ill   tkn
    vecs.push_back('{2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 16'h3C05, 16'h0042, 1'b0, 16'h0000, 16'h0042, 16'h3C05, 16'h0042, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0100, 1'b0, 16'h0000, 16'h0042, 16'h3C05, 16'h0100, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0100, 16'h3C05, 16'h0000, 1'b0, 1'b1});
    vecs.push_back('{2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0200, 1'b0, 16'h0000, 16'h0100, 16'h3C05, 16'h0200, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h0200, 1'b0, 16'h0000, 16'h0100, 16'h3C05, 16'h0200, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 16'h0000, 16'h0300, 1'b0, 16'h0000, 16'h0200, 16'h3C05, 16'h0300, 1'b0, 1'b1});
    vecs.push_back('{2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 16'h0000, 16'h0300, 1'b1, 16'h0000, 16'h0200, 16'h3C05, 16'h0300, 1'b0, 1'b0});
    vecs.push_back('{2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1235, 16'h1234, 16'h3C05, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h2010, 16'h0000, 1'b0, 16'h0000, 16'h1234, 16'h2010, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0457, 1'b0, 16'h0000, 16'h1020, 16'h2010, 16'h0457, 1'b0, 1'b0});
    vecs.push_back('{2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0456, 16'h2010, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{2'd1, 2'd0, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h0600, 1'b1, 16'h0000, 16'h0600, 16'h2010, 16'h0600, 1'b0, 1'b1});
    vecs.push_back('{2'd2, 2'd0, 2'd2, 2'd0, 1'b0, 16'h0000, 16'h0700, 1'b0, 16'h0000, 16'h0600, 16'h2010, 16'h0700, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h4F80, 16'h0000, 1'b0, 16'h0000, 16'h0600, 16'h4F80, 16'h0000, 1'b0, 1'b0});
    vecs.push_back('{2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h5000, 16'h0000, 1'b0, 16'h0000, 16'h0600, 16'h5000, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 16'h3C05, 16'h0602, 1'b0, 16'h0000, 16'h0602, 16'h3C05, 16'h0602, 1'b1, 1'b0});

    // Reset values while reset is held
    #12;
    chk("rst PC", {16'd0, PC}, 32'h0040);
    chk("rst IR", {16'd0, IR}, 32'h0);
    chk("rst ALUOut", {16'd0, ALUOut}, 32'h0);
    chk("rst IllegalOp", {31'd0, IllegalOp}, 32'h0);
    @(negedge CLK);
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Asynchronous reset between edges clears state immediately
    @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    chk("async PC", {16'd0, PC}, 32'h0040);
    chk("async IR", {16'd0, IR}, 32'h0);
    chk("async ALUOut", {16'd0, ALUOut}, 32'h0);
    chk("async IllegalOp", {31'd0, IllegalOp}, 32'h0);
    @(negedge CLK);
    Reset = 1'b1;
    apply(100, '{2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 16'hFC00, 16'h0042, 1'b0, 16'h0000,
                 16'h0042, 16'hFC00, 16'h0042, 1'b1, 1'b0});
    apply(101, '{2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0401, 16'h0044, 1'b0, 16'h0000,
                 16'h0044, 16'h0401, 16'h0044, 1'b1, 1'b0});

    // Opcode 0 is illegal too
    do_reset();
    apply(102, '{2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                 16'h0040, 16'h0000, 16'h0000, 1'b1, 1'b0});

`ifdef PC_IR_PERF_EN
    do_reset();
    chk("perf rst instr", InstrCount, 32'd0);
    chk("perf rst taken", {16'd0, BranchTakenCount}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      idle();
      IRWrite = 1'b1; MemRdata = 16'h0401;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      idle();
      Branch = 2'd1; BneOrBeq = 2'd1; Zero = 1'b1;
    end
    @(negedge CLK);
    idle();
    chk("perf instr", InstrCount, 32'd3);
    chk("perf taken", {16'd0, BranchTakenCount}, 32'd2);
    Branch = 2'd1; BneOrBeq = 2'd0; Zero = 1'b0;
    for (int i = 0; i < 65533; i++) @(negedge CLK);
    idle();
    chk("perf taken max", {16'd0, BranchTakenCount}, 32'hFFFF);
    Branch = 2'd1; BneOrBeq = 2'd0; Zero = 1'b0;
    @(negedge CLK);
    idle();
    chk("perf taken sat", {16'd0, BranchTakenCount}, 32'hFFFF);
    chk("perf instr hold", InstrCount, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
